// File: rtl/core_mem_arbiter.sv
// ---------------------------------------------------------------------------
// core_mem_arbiter
//  Round-robin arbiter that shares one memory controller port among
//  NUM_CORES requesters (eight standard cores plus the probabilistic core).
//  A single transaction is in flight at a time: IDLE picks a requester,
//  ISSUE/WAIT hold mem_req until mem_ready or a timeout, and RESP returns a
//  one-cycle done pulse with read data (or err on timeout).
//
// Ports
//  clk_i        clock, all logic on rising edge
//  rst_i        synchronous active-high reset
//  req_i        per-core request, held by the core until its done pulse
//  req_we_i     per-core write enable (1 = write, 0 = read)
//  req_addr_i   packed per-core address, core i at [i*ADDR_W +: ADDR_W]
//  req_wdata_i  packed per-core write data, core i at [i*DATA_W +: DATA_W]
//  gnt_o        one-hot grant, high for the whole transaction
//  done_o       one-cycle completion pulse to the granted core
//  rdata_o      read data, valid while done_o != 0
//  err_o        timeout abort flag, pulses together with done_o
//  busy_o       high whenever the arbiter is not idle
//  mem_req_o    memory request, held until mem_ready_i
//  mem_we_o     memory write enable
//  mem_addr_o   memory address
//  mem_wdata_o  memory write data
//  mem_ready_i  memory accept/complete strobe
//  mem_rdata_i  memory read data, valid with mem_ready_i
// ---------------------------------------------------------------------------
module core_mem_arbiter #(
  parameter int NUM_CORES = 9,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 15
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_CORES-1:0]        req_i,
  input  logic [NUM_CORES-1:0]        req_we_i,
  input  logic [NUM_CORES*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_CORES*DATA_W-1:0] req_wdata_i,
  output logic [NUM_CORES-1:0]        gnt_o,
  output logic [NUM_CORES-1:0]        done_o,
  output logic [DATA_W-1:0]           rdata_o,
  output logic                        err_o,
  output logic                        busy_o,
  output logic                        mem_req_o,
  output logic                        mem_we_o,
  output logic [ADDR_W-1:0]           mem_addr_o,
  output logic [DATA_W-1:0]           mem_wdata_o,
  input  logic                        mem_ready_i,
  input  logic [DATA_W-1:0]           mem_rdata_i
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // First requester at or after ptr, searching upward with wrap-around.
  function automatic logic [IDX_W-1:0] pick_next(input logic [NUM_CORES-1:0] r,
                                                  input logic [IDX_W-1:0]     p);
    logic [IDX_W-1:0] sel;
    logic             found;
    int               j;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_CORES; k++) begin
      j = int'(p) + k;
      j = (j >= NUM_CORES) ? (j - NUM_CORES) : j;
      if (!found && r[j]) begin
        sel   = IDX_W'(j);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  function automatic logic [NUM_CORES-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [NUM_CORES-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Registered state and latched transaction fields
  state_e               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 we_q, we_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [CNT_W-1:0]     count_q, count_d;

  // Registered outputs
  logic [NUM_CORES-1:0] gnt_q, gnt_d;
  logic [NUM_CORES-1:0] done_q, done_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;
  logic                 mem_req_q, mem_req_d;
  logic                 mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;

  logic [IDX_W-1:0]     sel_idx_s;

  // Next-state and next-output logic; outputs are derived from the next
  // state so that the registered outputs line up with the state they describe.
  always_comb begin
    sel_idx_s = pick_next(req_i, ptr_q);
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    count_d   = count_q;
    rdata_d   = '0;
    err_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_i != '0) begin
          idx_d   = sel_idx_s;
          we_d    = req_we_i[sel_idx_s];
          addr_d  = req_addr_i[int'(sel_idx_s)*ADDR_W +: ADDR_W];
          wdata_d = req_wdata_i[int'(sel_idx_s)*DATA_W +: DATA_W];
          count_d = CNT_W'(1);
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE, ST_WAIT: begin
        // A ready on the final allowed cycle still counts as success.
        if (mem_ready_i) begin
          rdata_d = we_q ? '0 : mem_rdata_i;
          state_d = ST_RESP;
        end else if (count_q == CNT_W'(TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          count_d = count_q + CNT_W'(1);
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        ptr_d   = (idx_q == IDX_W'(NUM_CORES - 1)) ? '0 : (idx_q + IDX_W'(1));
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d    = (state_d != ST_IDLE);
    mem_req_d = (state_d == ST_ISSUE) || (state_d == ST_WAIT);
    if (mem_req_d) begin
      mem_we_d    = we_d;
      mem_addr_d  = addr_d;
      mem_wdata_d = wdata_d;
    end else begin
      mem_we_d    = 1'b0;
      mem_addr_d  = '0;
      mem_wdata_d = '0;
    end
    gnt_d  = busy_d ? onehot(idx_d) : '0;
    done_d = (state_d == ST_RESP) ? onehot(idx_d) : '0;
  end

  // State, latched fields and output registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      idx_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      count_q     <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      count_q     <= count_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign done_o      = done_q;
  assign rdata_o     = rdata_q;
  assign err_o       = err_q;
  assign busy_o      = busy_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_core_mem_arbiter
//  Scoreboard bench: each expected transaction (core, fields, read data,
//  err, number of mem_req cycles) is queued when the stimulus is set up and
//  checked when mem_req / done appear. A memory responder raises mem_ready
//  after a programmable number of request cycles.
// ---------------------------------------------------------------------------
module tb_core_mem_arbiter;

  localparam int NC = 9;
  localparam int AW = 8;
  localparam int DW = 32;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic [NC-1:0]     req_i = '0;
  logic [NC-1:0]     req_we_i = '0;
  logic [NC*AW-1:0]  req_addr_i = '0;
  logic [NC*DW-1:0]  req_wdata_i = '0;
  logic [NC-1:0]     gnt_o;
  logic [NC-1:0]     done_o;
  logic [DW-1:0]     rdata_o;
  logic              err_o;
  logic              busy_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [AW-1:0]     mem_addr_o;
  logic [DW-1:0]     mem_wdata_o;
  logic              mem_ready_i = 1'b0;
  logic [DW-1:0]     mem_rdata_i = 32'hBAD0BAD0;

  core_mem_arbiter #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(15)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .gnt_o(gnt_o),
    .done_o(done_o), .rdata_o(rdata_o), .err_o(err_o), .busy_o(busy_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          idx;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          cycles;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          mreq_cnt = 0;
  int          ready_delay = 0;
  logic [31:0] rd_pattern = 32'h0;
  logic        noise_en = 1'b0;
  logic        hold_req = 1'b0;
  logic        spacing_en = 1'b0;
  logic        have_last = 1'b0;
  int          last_done = 0;
  logic        c_we [NC];
  logic [7:0]  c_addr [NC];
  logic [31:0] c_wdata [NC];

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [NC-1:0] onehot(input int i);
    logic [NC-1:0] v;
    v = 9'd1;
    return v << i;
  endfunction

  task automatic set_core(input int i, input logic we, input logic [7:0] addr, input logic [31:0] wdata);
    c_we[i]    = we;
    c_addr[i]  = addr;
    c_wdata[i] = wdata;
    req_we_i[i] = we;
    req_addr_i[i*AW +: AW]  = addr;
    req_wdata_i[i*DW +: DW] = wdata;
  endtask

  task automatic push_exp(input int i, input int cycles, input logic err);
    exp_t e;
    e.idx    = i;
    e.we     = c_we[i];
    e.addr   = c_addr[i];
    e.wdata  = c_wdata[i];
    e.err    = err;
    e.cycles = cycles;
    e.rdata  = (err || c_we[i]) ? 32'h0 : rd_pattern;
    sb.push_back(e);
  endtask

  // Per-cycle observer and memory responder, called at every falling edge.
  task automatic monitor();
    exp_t e;
    cyc++;
    if (rst_i) begin
      mreq_cnt    = 0;
      mem_ready_i = 1'b0;
      mem_rdata_i = 32'hBAD0BAD0;
    end else begin
      if (mem_req_o) begin
        if (sb.size() == 0) begin
          chk_eq("mem_req_spurious", 32'(mem_req_o), 32'd0);
        end else begin
          e = sb[0];
          chk_eq("mem_we", 32'(mem_we_o), 32'(e.we));
          chk_eq("mem_addr", 32'(mem_addr_o), 32'(e.addr));
          chk_eq("mem_wdata", mem_wdata_o, e.wdata);
          chk_eq("gnt_during_req", 32'(gnt_o), 32'(onehot(e.idx)));
          chk_eq("busy_during_req", 32'(busy_o), 32'd1);
        end
        mreq_cnt++;
      end
      if (done_o != '0) begin
        if (sb.size() == 0) begin
          chk_eq("done_spurious", 32'(done_o), 32'd0);
        end else begin
          e = sb.pop_front();
          chk_eq("done", 32'(done_o), 32'(onehot(e.idx)));
          chk_eq("gnt_at_done", 32'(gnt_o), 32'(onehot(e.idx)));
          chk_eq("rdata", rdata_o, e.rdata);
          chk_eq("err", 32'(err_o), 32'(e.err));
          chk_eq("mem_req_cycles", 32'(mreq_cnt), 32'(e.cycles));
          chk_eq("mem_req_at_done", 32'(mem_req_o), 32'd0);
          if (spacing_en && have_last) chk_eq("done_spacing", 32'(cyc - last_done), 32'd3);
          have_last = 1'b1;
          last_done = cyc;
          mreq_cnt  = 0;
          if (sb.size() == 0) req_i = '0;
          else if (!hold_req) req_i[e.idx] = 1'b0;
        end
      end else begin
        chk_eq("err_without_done", 32'(err_o), 32'd0);
      end
      mem_ready_i = mem_req_o && (ready_delay >= 0) && (mreq_cnt == ready_delay + 1);
      mem_rdata_i = mem_ready_i ? rd_pattern : 32'hBAD0BAD0;
      if (noise_en && !mem_req_o) mem_ready_i = 1'b1;
    end
  endtask

  task automatic step();
    @(negedge clk_i);
    monitor();
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk_eq({tag, "_drained"}, 32'(sb.size()), 32'd0);
    sb.delete();
    repeat (2) step();
  endtask

  task automatic chk_zero(input string tag);
    chk_eq({tag, "_gnt"}, 32'(gnt_o), 32'd0);
    chk_eq({tag, "_done"}, 32'(done_o), 32'd0);
    chk_eq({tag, "_rdata"}, rdata_o, 32'd0);
    chk_eq({tag, "_err"}, 32'(err_o), 32'd0);
    chk_eq({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk_eq({tag, "_mem_req"}, 32'(mem_req_o), 32'd0);
    chk_eq({tag, "_mem_we"}, 32'(mem_we_o), 32'd0);
    chk_eq({tag, "_mem_addr"}, 32'(mem_addr_o), 32'd0);
    chk_eq({tag, "_mem_wdata"}, mem_wdata_o, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < NC; i++) set_core(i, 1'b0, 8'h00, 32'h0);
    rst_i = 1'b1;
    repeat (3) step();
    chk_zero("reset");
    rst_i = 1'b0;
    step();

    // All nine cores requesting from reset: 0..8 then wrap to 0, one per 3 cycles.
    ready_delay = 0;
    rd_pattern  = 32'hA5A55A5A;
    noise_en    = 1'b1;
    hold_req    = 1'b1;
    spacing_en  = 1'b1;
    have_last   = 1'b0;
    for (int i = 0; i < NC; i++) set_core(i, i[0], 8'(8'h20 + i), 32'hC0DE0000 + 32'(i));
    for (int i = 0; i < NC; i++) push_exp(i, 1, 1'b0);
    push_exp(0, 1, 1'b0);
    req_i = '1;
    drain("all9", 100);
    noise_en   = 1'b0;
    hold_req   = 1'b0;
    spacing_en = 1'b0;

    // Single write from core 3 with immediate ready; cycle-exact latency.
    set_core(3, 1'b1, 8'h10, 32'hDEADBEEF);
    push_exp(3, 1, 1'b0);
    req_i = 9'b000001000;
    step();
    chk_eq("t1_mem_req_T1", 32'(mem_req_o), 32'd1);
    chk_eq("t1_gnt_T1", 32'(gnt_o), 32'h008);
    chk_eq("t1_busy_T1", 32'(busy_o), 32'd1);
    chk_eq("t1_done_T1", 32'(done_o), 32'd0);
    step();
    chk_eq("t1_done_T2", 32'(done_o), 32'h008);
    chk_eq("t1_err_T2", 32'(err_o), 32'd0);
    chk_eq("t1_mem_req_T2", 32'(mem_req_o), 32'd0);
    step();
    chk_eq("t1_busy_T3", 32'(busy_o), 32'd0);
    chk_eq("t1_gnt_T3", 32'(gnt_o), 32'd0);
    chk_eq("t1_done_T3", 32'(done_o), 32'd0);
    drain("t1", 20);

    // Read by core 8, ready after 4 waiting cycles.
    rd_pattern  = 32'h12345678;
    ready_delay = 4;
    set_core(8, 1'b0, 8'hF8, 32'h0000FFFF);
    push_exp(8, 5, 1'b0);
    req_i = 9'b100000000;
    drain("t3", 40);

    // Ready on the last allowed cycle is a success.
    rd_pattern  = 32'h0F0F1234;
    ready_delay = 14;
    set_core(4, 1'b0, 8'h44, 32'h44444444);
    push_exp(4, 15, 1'b0);
    req_i = 9'b000010000;
    drain("edge15", 40);

    // No ready at all: abort after 15 request cycles.
    rd_pattern  = 32'h77777777;
    ready_delay = -1;
    noise_en    = 1'b1;
    set_core(2, 1'b0, 8'h22, 32'h22222222);
    push_exp(2, 15, 1'b1);
    req_i = 9'b000000100;
    drain("timeout", 40);
    noise_en = 1'b0;

    // Reset during WAIT of core 5, then core 0 must win over core 5.
    set_core(5, 1'b0, 8'h55, 32'h55555555);
    push_exp(5, 1, 1'b0);
    req_i = 9'b000100000;
    repeat (4) step();
    chk_eq("t5_in_wait", 32'(mem_req_o), 32'd1);
    rst_i = 1'b1;
    step();
    chk_zero("t5_after_rst");
    sb.delete();
    req_i = '0;
    step();
    ready_delay = 0;
    rd_pattern  = 32'h00C0FFEE;
    set_core(0, 1'b1, 8'h01, 32'h01010101);
    push_exp(0, 1, 1'b0);
    push_exp(5, 1, 1'b0);
    req_i = 9'b000100001;
    rst_i = 1'b0;
    drain("t5", 40);

    // After core 0 (ptr=1), core 8 precedes core 0.
    push_exp(0, 1, 1'b0);
    req_i = 9'b000000001;
    drain("t6a", 20);
    set_core(8, 1'b1, 8'h88, 32'h88888888);
    push_exp(8, 1, 1'b0);
    push_exp(0, 1, 1'b0);
    req_i = 9'b100000001;
    drain("t6", 40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
